// File: rtl/alu_pkg.sv
// Shared types for the pipelined add/sub/compare unit.
package alu_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_SLT  = 2'b10,
        OP_SLTU = 2'b11
    } addsub_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } addsub_flags_t;

    // Every mode except ADD computes a - b.
    function automatic logic is_sub(input addsub_op_e op);
        return op != OP_ADD;
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// One carry segment of the add/sub datapath: purely combinational.
module addsub_seg
    import alu_pkg::*;
#(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_seg,
    input  logic           cin,
    output logic [SEG-1:0] sum_seg,
    output logic           cout,
    output logic           c_msb
);

    // Segment sum with carry out; the carry into the MSB is recovered from the MSB sum bit.
    always_comb begin
        {cout, sum_seg} = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, cin};
        c_msb           = sum_seg[SEG-1] ^ a_seg[SEG-1] ^ b_seg[SEG-1];
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub/compare unit: STAGES registered carry segments, valid/ready on both sides.
module addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  addsub_op_e       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output addsub_flags_t    flags
);

    localparam int SEG = WIDTH / STAGES;

    // One pipeline slot: operands travel along so later stages can add their segment.
    typedef struct packed {
        logic             vld;
        addsub_op_e       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;     // already inverted for subtract
        logic [WIDTH-1:0] sum;   // bits below the current segment are final
        logic             carry; // carry into the next segment
        logic             c_msb; // carry into the MSB, valid once the last segment is added
    } stage_t;

    stage_t         src     [STAGES];
    stage_t         st_d    [STAGES];
    stage_t         st_q    [STAGES];
    logic [SEG-1:0] seg_sum [STAGES];
    logic           seg_cout[STAGES];
    logic           seg_cmsb[STAGES];
    logic           advance;
    addsub_flags_t  s_flags;

    // The whole pipeline moves only when the output slot is empty or being drained.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage inputs: stage 0 takes the port beat, every later stage takes its predecessor.
    always_comb begin
        src[0].vld   = in_valid;
        src[0].op    = op;
        src[0].a     = a;
        src[0].b     = is_sub(op) ? ~b : b;
        src[0].sum   = '0;
        src[0].carry = is_sub(op);
        src[0].c_msb = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = st_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        addsub_seg #(.SEG(SEG)) u_seg (
            .a_seg  (src[k].a[k*SEG +: SEG]),
            .b_seg  (src[k].b[k*SEG +: SEG]),
            .cin    (src[k].carry),
            .sum_seg(seg_sum[k]),
            .cout   (seg_cout[k]),
            .c_msb  (seg_cmsb[k])
        );
    end

    // Next slot contents: shift in the freshly added segment, or hold everything on stall.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            // NOTE: hold value assigned first so every path drives st_d and no latch is inferred.
            st_d[k] = st_q[k];
            if (advance) begin
                st_d[k]                    = src[k];
                st_d[k].sum[k*SEG +: SEG]  = seg_sum[k];
                st_d[k].carry              = seg_cout[k];
                if (k == STAGES - 1) begin
                    st_d[k].c_msb = seg_cmsb[k];
                end
            end
        end
    end

    // Stage registers; reset drops every in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the datapath is cleared along with the valid bits so an idle unit reads all-zero.
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    // Last slot holds the full sum: derive flags, select the mode result, zero while empty.
    always_comb begin
        s_flags.n = st_q[STAGES-1].sum[WIDTH-1];
        s_flags.z = (st_q[STAGES-1].sum == '0);
        s_flags.c = st_q[STAGES-1].carry;
        s_flags.v = st_q[STAGES-1].carry ^ st_q[STAGES-1].c_msb;
        out_valid = st_q[STAGES-1].vld;
        result    = st_q[STAGES-1].sum;
        case (st_q[STAGES-1].op)
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, s_flags.n ^ s_flags.v};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, ~s_flags.c};
            default: ;
        endcase
        flags = s_flags;
        if (!out_valid) begin
            result = '0;
            flags  = '0;
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: 32-bit/2-stage and 16-bit/4-stage instances with scoreboards.
module tb_addsub_pipe;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          in_valid, in_ready, out_valid, out_ready;
    logic [31:0]   a, b, result;
    addsub_op_e    op;
    addsub_flags_t flags;

    logic          h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0]   h_a, h_b, h_result;
    addsub_op_e    h_op;
    addsub_flags_t h_flags;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out32  = 0;
    int   n_out16  = 0;
    exp_t q32[$];
    exp_t q16[$];

    addsub_pipe #(.WIDTH(32), .STAGES(2)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    addsub_pipe #(.WIDTH(16), .STAGES(4)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .op(h_op),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .flags(h_flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
        end
    endtask

    // Reference: w-bit add/sub with the textbook same-sign overflow rule.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input addsub_op_e o, input int w);
        longint unsigned mask, xx, yy, full, s;
        logic sub, n, z, c, v;
        exp_t e;
        mask = (64'd1 << w) - 64'd1;
        sub  = (o != OP_ADD);
        xx   = {32'd0, x} & mask;
        yy   = sub ? (~{32'd0, y} & mask) : ({32'd0, y} & mask);
        full = xx + yy + {63'd0, sub};
        s    = full & mask;
        c    = full[w];
        n    = s[w-1];
        z    = (s == 0);
        v    = (xx[w-1] == yy[w-1]) && (n != xx[w-1]);
        e.flg = {n, z, c, v};
        case (o)
            OP_SLT:  e.res = {31'd0, n ^ v};
            OP_SLTU: e.res = {31'd0, ~c};
            default: e.res = s[31:0];
        endcase
        return e;
    endfunction

    // Scoreboards: sampled on the falling edge, where the coming handshake is already settled.
    always @(negedge clk) begin : mon32
        exp_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_out32++;
                if (q32.size() == 0) begin
                    check("dut32 unexpected beat", 32'(out_valid), 32'd0);
                end else begin
                    e = q32.pop_front();
                    check("dut32 result", result, e.res);
                    check("dut32 flags", 32'(flags), 32'(e.flg));
                end
            end
            if (in_valid && in_ready) q32.push_back(model(a, b, op, 32));
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (!rst) begin
            if (h_out_valid && h_out_ready) begin
                n_out16++;
                if (q16.size() == 0) begin
                    check("dut16 unexpected beat", 32'(h_out_valid), 32'd0);
                end else begin
                    e = q16.pop_front();
                    check("dut16 result", 32'(h_result), e.res);
                    check("dut16 flags", 32'(h_flags), 32'(e.flg));
                end
            end
            if (h_in_valid && h_in_ready) q16.push_back(model({16'd0, h_a}, {16'd0, h_b}, h_op, 16));
        end
    end

    // Drivers start and return at posedge+1; in_valid is left high for back-to-back streaming.
    task automatic send32(input logic [31:0] x, input logic [31:0] y, input addsub_op_e o);
        logic acc;
        int   guard;
        in_valid = 1'b1; a = x; b = y; op = o;
        acc = 1'b0; guard = 0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (!acc) check("dut32 accept timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send16(input logic [15:0] x, input logic [15:0] y, input addsub_op_e o);
        logic acc;
        int   guard;
        h_in_valid = 1'b1; h_a = x; h_b = y; h_op = o;
        acc = 1'b0; guard = 0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = h_in_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (!acc) check("dut16 accept timeout", 32'(h_in_ready), 32'd1);
    endtask

    // Latency counted in rising edges, the accept edge being the first.
    task automatic lat32(input int want);
        int lat = 1;
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("dut32 latency", 32'(lat), 32'(want));
    endtask

    task automatic lat16(input int want);
        int lat = 1;
        h_in_valid = 1'b0;
        while (!h_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("dut16 latency", 32'(lat), 32'(want));
    endtask

    task automatic drain();
        int guard = 0;
        in_valid   = 1'b0;
        h_in_valid = 1'b0;
        while ((q32.size() != 0 || q16.size() != 0) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("scoreboard drained", 32'(q32.size() + q16.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, want self-termination");
        $fatal(1);
    end

    initial begin : main
        int base;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; op = OP_ADD; out_ready = 1'b1;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_op = OP_ADD; h_out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", 32'(flags), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset dut16 out_valid", 32'(h_out_valid), 32'd0);
        rst = 1'b0;
        check("in_ready after reset", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Basic ADD with latency, and full-width wrap
        send32(32'd10, 32'd5, OP_ADD);
        lat32(2);
        send32(32'hFFFF_FFFF, 32'd1, OP_ADD);
        drain();

        // SUB borrow, SUB to zero, signed overflow
        send32(32'd5, 32'd20, OP_SUB);
        send32(32'd10, 32'd10, OP_SUB);
        send32(32'h7FFF_FFFF, 32'd1, OP_ADD);
        drain();

        // Compares
        send32(32'hFFFF_FFFF, 32'd1, OP_SLT);
        send32(32'hFFFF_FFFF, 32'd1, OP_SLTU);
        send32(32'h8000_0000, 32'h7FFF_FFFF, OP_SLT);
        drain();

        // Eight-beat stream with a three-cycle output stall in the middle
        base = n_out32;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send32($urandom, $urandom, addsub_op_e'(2'(i)));
                end
                in_valid = 1'b0;
            end
            begin : stall_blk
                logic [31:0] held_r;
                logic [31:0] held_f;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check("stall in_ready", 32'(in_ready), 32'd0);
                    check("stall out_valid", 32'(out_valid), 32'd1);
                    if (j == 0) begin
                        held_r = result;
                        held_f = 32'(flags);
                    end else begin
                        check("stall result hold", result, held_r);
                        check("stall flags hold", 32'(flags), held_f);
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("stream beat count", 32'(n_out32 - base), 32'd8);

        // Reset with two beats in flight
        send32(32'd100, 32'd23, OP_ADD);
        send32(32'd7, 32'd8, OP_SUB);
        in_valid = 1'b0;
        check("in flight before reset", 32'(out_valid), 32'd1);
        rst = 1'b1;
        q32.delete();
        #1;
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset result", result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        base = n_out32;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("no stale output after reset", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send32(32'd123, 32'd456, OP_SUB);
        lat32(2);
        drain();
        check("one beat after reset", 32'(n_out32 - base), 32'd1);

        // 16-bit, 4-stage instance: carry across segments and full wrap
        send16(16'h00FF, 16'h0001, OP_ADD);
        lat16(4);
        send16(16'hFFFF, 16'h0001, OP_ADD);
        send16(16'h8000, 16'h0001, OP_SLT);
        send16(16'h1234, 16'h4321, OP_SUB);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
